// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with fixed-priority or round-robin selection and a hold timeout.
// Latency: a grant appears 1 cycle after the request. Every release is followed by one idle cycle before the next grant.
module prio_arbiter #(
    parameter int N        = 8,
    parameter int IW       = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          rr_mode,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt_oh,
    output logic          timeout
);

    // The counter keeps one bit when MAX_HOLD is 0, so it never has zero width.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    int            j;

    // Downward search from start_idx with wrap. Round-robin starts just below the last grantee.
    always_comb begin
        start_idx = IW'(N - 1);
        if (rr_mode) begin
            start_idx = (last_idx == '0) ? IW'(N - 1) : last_idx - IW'(1);
        end
        sel_idx   = '0;
        sel_found = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start_idx) - i;
            if (j < 0) begin
                j = j + N;
            end
            if (!sel_found && req[IW'(j)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last_idx  <= '0;
        end else begin
            timeout <= 1'b0;
            if (state == S_IDLE) begin
                if (en && sel_found) begin
                    state     <= S_GRANT;
                    gnt_valid <= 1'b1;
                    gnt_idx   <= sel_idx;
                    gnt_oh    <= N'(1) << sel_idx;
                    hold_cnt  <= HW'(1);
                    last_idx  <= sel_idx;
                end
            end else begin
                // done has priority over an expiring hold, which suppresses the timeout pulse.
                if (done) begin
                    state     <= S_IDLE;
                    gnt_valid <= 1'b0;
                    gnt_oh    <= '0;
                    hold_cnt  <= '0;
                end else if ((MAX_HOLD > 0) && (hold_cnt == HW'(MAX_HOLD))) begin
                    state     <= S_IDLE;
                    gnt_valid <= 1'b0;
                    gnt_oh    <= '0;
                    hold_cnt  <= '0;
                    timeout   <= 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=8, MAX_HOLD=4); expected grant indices are queued at stimulus time and checked when each grant starts.
module tb_prio_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_oh;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int rr_seq[$] = '{7, 0, 7, 0, 7, 6, 5, 4, 3, 2, 1, 0, 7};
    logic prev_v = 1'b0;

    prio_arbiter #(.N(8), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rr_mode  (rr_mode),
        .req      (req),
        .done     (done),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx),
        .gnt_oh   (gnt_oh),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every new grant must match the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (gnt_valid === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant observed_idx=%0d expected=none", gnt_idx);
            end else begin
                int e;
                logic [7:0] eo;
                e  = exp_q.pop_front();
                eo = 8'd1 << e;
                chk("grant_idx", 32'(gnt_idx), 32'(e));
                chk("grant_oh", 32'(gnt_oh), 32'(eo));
            end
        end
        prev_v = gnt_valid;
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; rr_mode = 1'b0; req = 8'hFF; done = 1'b0;
        tick(); tick();
        chk("reset_valid", 32'(gnt_valid), 32'(0));
        chk("reset_oh", 32'(gnt_oh), 32'(0));
        chk("reset_idx", 32'(gnt_idx), 32'(0));
        chk("reset_timeout", 32'(timeout), 32'(0));

        rst_n = 1'b1;
        exp_q.push_back(7);
        tick();
        chk("first_grant_latency", 32'(gnt_valid), 32'(1));

        done = 1'b1; req = 8'b0000_1011;
        tick();
        done = 1'b0;
        chk("done_release_valid", 32'(gnt_valid), 32'(0));
        chk("done_release_oh", 32'(gnt_oh), 32'(0));
        chk("done_idx_kept", 32'(gnt_idx), 32'(7));

        exp_q.push_back(3);
        tick();
        chk("fixed_oh", 32'(gnt_oh), 32'(8'h08));
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_q.push_back(3);
        tick();
        req = 8'h00;
        tick();
        chk("req_drop_valid", 32'(gnt_valid), 32'(1));
        chk("req_drop_idx", 32'(gnt_idx), 32'(3));
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("fixed_release", 32'(gnt_valid), 32'(0));

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; rr_mode = 1'b1; req = 8'h81;
        for (int i = 0; i < rr_seq.size(); i++) begin
            if (i == 4) req = 8'hFF;
            exp_q.push_back(rr_seq[i]);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = 8'h00;

        rr_mode = 1'b0; req = 8'h10;
        exp_q.push_back(4);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", 32'(gnt_valid), 32'(1));
            chk("hold_no_timeout", 32'(timeout), 32'(0));
            tick();
        end
        chk("timeout_release", 32'(gnt_valid), 32'(0));
        chk("timeout_pulse", 32'(timeout), 32'(1));
        exp_q.push_back(4);
        tick();
        chk("timeout_cleared", 32'(timeout), 32'(0));
        chk("timeout_regrant", 32'(gnt_valid), 32'(1));

        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        chk("done_vs_timeout_valid", 32'(gnt_valid), 32'(0));
        chk("done_vs_timeout_pulse", 32'(timeout), 32'(0));
        tick();
        chk("done_vs_timeout_later", 32'(timeout), 32'(0));

        rr_mode = 1'b1; req = 8'h20;
        exp_q.push_back(5);
        tick();
        rst_n = 1'b0; en = 1'b0; req = 8'h90;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 32'(gnt_valid), 32'(0));
        chk("midrst_idx", 32'(gnt_idx), 32'(0));
        chk("midrst_oh", 32'(gnt_oh), 32'(0));
        chk("midrst_timeout", 32'(timeout), 32'(0));
        tick(); tick();
        chk("en_block", 32'(gnt_valid), 32'(0));
        en = 1'b1;
        exp_q.push_back(7);
        tick();
        chk("rr_restart_idx", 32'(gnt_idx), 32'(7));
        en = 1'b0;
        tick();
        chk("en_low_keeps_grant", 32'(gnt_valid), 32'(1));
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h20;
        tick(); tick();
        chk("en_block2", 32'(gnt_valid), 32'(0));
        en = 1'b1;
        exp_q.push_back(5);
        tick();
        chk("en_grant5", 32'(gnt_idx), 32'(5));
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
Parametrised, registered successor to the 4-input combinational priority encoder. Accepts N request lines and issues one grant (binary index and one-hot) through an IDLE/GRANT state machine. Fixed-priority mode (highest index wins) and round-robin mode are selectable. The grant is held until the requester signals done or a hold-timeout expires. Used as the shared-resource arbiter in lab datapaths.

Parameters:
N, 8, number of requesters (2..32)
IW, $clog2(N), width of grant index
MAX_HOLD, 16, max cycles a grant may be held; 0 = unlimited

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  arbitration enable; new grants only when 1
rr_mode  input  1  0 = fixed priority, 1 = round-robin
req  input  N  request vector, bit i = requester i
done  input  1  current grantee releases grant
gnt_valid  output  1  a grant is active
gnt_idx  output  IW  index of granted requester
gnt_oh  output  N  one-hot grant, equals 1<<gnt_idx when valid, else 0
timeout  output  1  one-cycle pulse: grant force-released by MAX_HOLD

Behaviour:
- Reset: one clock, synchronous, active-low.
  - On the first rising clk edge with rst_n=0: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_oh=0, timeout=0, hold counter=0, last_idx=0.
  - Reset during GRANT drops the grant at that edge. It overrides done and req.
- All outputs are registered. There is no combinational path from inputs to outputs.
- IDLE:
  - Condition: en=1 and req!=0 at edge k.
  - Result at edge k: state=GRANT, gnt_valid=1, gnt_idx=selected, gnt_oh=one-hot of selected, hold counter=1.
  - Latency from req to grant: 1 cycle.
  - done is ignored in IDLE. en=0 or req=0 keeps IDLE with outputs zero.
- Selection, fixed mode (rr_mode=0): the highest set bit of req wins (bit N-1 has top priority).
- Selection, round-robin mode (rr_mode=1):
  - Search starts at (last_idx-1) mod N and proceeds downward, wrapping from 0 to N-1.
  - The first set bit wins. The last grantee therefore has the lowest priority.
  - After reset (last_idx=0) the search starts at N-1, which is identical to fixed mode.
- last_idx update: loaded with gnt_idx on every grant, in both modes.
- rr_mode is sampled only in IDLE. Toggling it during GRANT has no effect on the active grant.
- GRANT:
  - gnt_idx and gnt_oh are held stable. Changes to req, including the grantee dropping its bit, do not alter the grant.
  - The hold counter increments each cycle.
  - done=1 at an edge: state=IDLE, gnt_valid=0, gnt_oh=0 after that edge. gnt_idx keeps its last value.
  - Timeout (MAX_HOLD>0 and done=0): the grant is cleared after gnt_valid has been high for exactly MAX_HOLD cycles. timeout=1 for the single cycle in which gnt_valid is first low, then 0.
  - done and timeout expiring in the same cycle: done wins and timeout stays 0.
- Mandatory bubble: one cycle with gnt_valid=0 follows every grant release. Re-arbitration happens in that IDLE cycle, so back-to-back grants are spaced by one idle cycle.
- Hold counter width: $clog2(MAX_HOLD+1). It must not wrap when MAX_HOLD=0; in that case it saturates and is unused.
- en=0 during GRANT does not end the grant. It only blocks new grants.

Test Plan:
1. Reset: drive rst_n=0 with req=8'hFF for 2 edges -> gnt_valid=0, gnt_oh=0, gnt_idx=0, timeout=0. Release rst_n -> grant idx 7 appears one edge later.
2. Fixed priority: rr_mode=0, req=8'b0000_1011 -> one cycle later gnt_valid=1, gnt_idx=3, gnt_oh=8'h08. Assert done -> next cycle gnt_valid=0. With req unchanged, the grant after the bubble is again idx 3.
3. Round-robin fairness: rr_mode=1, req=8'h81 held, done pulsed one cycle after each grant -> grant sequence 7,0,7,0. Then req=8'hFF -> sequence continues 7,6,5,...,0,7.
4. Timeout: MAX_HOLD=4, req=8'h10, done never asserted -> gnt_idx=4 with gnt_valid high for exactly 4 cycles, then gnt_valid=0 and timeout=1 for one cycle. Regrant of idx 4 follows next cycle.
5. Simultaneous done and timeout: MAX_HOLD=4, done asserted in the 4th grant cycle -> gnt_valid drops, timeout stays 0.
6. Reset mid-grant and en gating: grant idx 5 active, rst_n=0 for one edge -> all outputs 0, and the following RR search starts at 7. With en=0 and req=8'h20 -> no grant. Raising en -> gnt_idx=5 one cycle later.
